alu_issue: RTL and testbench
============================

Name: alu_issue

Overview:
- Front end of the execute stage: the producer side of the ALU's 4-bit AluOp interface.
- Accepts a fetched RV32I instruction word and its PC over a valid/ready handshake.
- Decodes the instruction into AluOp, operand selects, the sign-extended immediate and an illegal flag.
- Presents the decoded result through a registered output stage with a 2-entry skid buffer, so upstream sees full throughput under downstream backpressure.

Parameters:
n, 32, datapath width of PC/Imm (instruction word is fixed at 32 bits)

Ports:
clock  input  1  system clock, rising edge
nReset  input  1  asynchronous active-low reset
InValid  input  1  instruction/PC valid
InReady  output  1  block can accept this cycle
Instr  input  32  RV32I instruction word
PcIn  input  n  PC of the instruction
OutValid  output  1  decoded bundle valid
OutReady  input  1  consumer accepts bundle
AluOp  output  4  ALU operation code
ASel  output  2  A operand: 00 rs1, 01 PC, 10 zero
BSel  output  1  B operand: 0 rs2, 1 Imm
Imm  output  n  sign-extended immediate
PcOut  output  n  PC passed through
Illegal  output  1  instruction not decodable

Behaviour:
- Reset (async, nReset=0):
  - OutValid=0, InReady=1, AluOp=0000, ASel=00, BSel=0, Imm=0, PcOut=0, Illegal=0.
  - Skid entry is marked empty.
- Transfer rules:
  - Input transfer when InValid&InReady. Output transfer when OutValid&OutReady.
  - Latency: a bundle accepted in cycle t has OutValid=1 in cycle t+1.
- Storage and states:
  - Two entries: output register (main) and skid register.
  - States: EMPTY (main empty), ONE (main full, skid empty), TWO (both full).
  - InReady = !skid_full. This is registered; there is no combinational path from OutReady to InReady.
- Transitions:
  - EMPTY + in → ONE.
  - ONE + in + out → ONE (main reloads).
  - ONE + in + !out → TWO (new bundle to skid).
  - ONE + !in + out → EMPTY.
  - TWO + out → ONE (skid moves to main). Input cannot be accepted in TWO.
- Ordering: bundles leave strictly in acceptance order.
- Output stability: while OutValid=1 and OutReady=0, all outputs hold stable.
- AluOp encoding: {funct3, alt}.
  - ADD 0000, SUB 0001, SLL 0010, SLT 0100, SLTU 0110, XOR 1000, SRL 1010, SRA 1011, OR 1100, AND 1110.
- Decode by opcode:
  - OP (0110011): alt=funct7[5]; ASel=00, BSel=0.
  - OP-IMM (0010011): alt=funct7[5] only for funct3=101, else 0; BSel=1.
    - Shift immediates: Imm = zero-extended shamt Instr[24:20].
  - LOAD (0000011), STORE (0100011): ADD, BSel=1, I/S immediate.
  - LUI (0110111): ADD, ASel=10, BSel=1, U immediate.
  - AUIPC (0010111): ADD, ASel=01, BSel=1, U immediate.
  - JAL (1101111): ADD, ASel=01, BSel=1, J immediate.
  - JALR (1100111): ADD, ASel=00, BSel=1, I immediate.
  - BRANCH (1100011): ASel=00, BSel=0, Imm = B immediate.
    - BEQ/BNE → SUB; BLT/BGE → SLT; BLTU/BGEU → SLTU; other funct3 → illegal.
- Illegal=1 when any of:
  - Instr[1:0]≠11;
  - unlisted opcode;
  - OP funct7 ∉ {0000000, 0100000}, or 0100000 with funct3 ∉ {000, 101};
  - OP-IMM shift with a bad funct7;
  - JALR funct3≠000.
- Illegal bundles still flow through the pipeline with AluOp=0000, ASel=00, BSel=0, Imm=0.
- Immediates are sign-extended from Instr[31] to n bits. U-type is Instr[31:12]<<12.
- Reset mid-operation: both entries are discarded immediately and OutValid drops asynchronously. No partial bundle emerges after reset release.

Decomposition:
- alu_pkg:
  - AluOp localparams (ALU_ADD…ALU_AND);
  - opcode localparams;
  - ASel enum (A_RS1, A_PC, A_ZERO);
  - decoded-bundle packed struct.
- Sub-module alu_decode: purely combinational Instr → bundle (AluOp, ASel, BSel, Imm, Illegal).
- alu_issue itself holds the skid/handshake logic only.

Test Plan:
- ADD x3,x1,x2: Instr=0x002081B3, PcIn=0x100, OutReady=1 → next cycle OutValid=1, AluOp=0000, ASel=00, BSel=0, PcOut=0x100, Illegal=0.
- SUB 0x402081B3 and SRAI x1,x2,3 0x40315093 back-to-back:
  - first bundle → AluOp=0001;
  - second bundle → AluOp=1011, BSel=1, Imm=0x00000003;
  - throughput 1 per cycle.
- LUI x5,0x12345: 0x123452B7 → AluOp=0000, ASel=10, BSel=1, Imm=0x12345000. BLTU → AluOp=0110, Imm = B offset sign-extended.
- Backpressure:
  - OutReady=0 while sending A,B,C each cycle → A accepted, B accepted into skid, InReady=0 on cycle 3 so C is held;
  - OutReady=1 → outputs A,B,C in order, no loss or duplication.
- Illegal: Instr=0x0000007F, and 0x002081B3 with funct7=0000001 → Illegal=1, AluOp=0000, bundle still delivered.
- Reset with two bundles buffered → OutValid=0 immediately and all outputs at reset values. After release, a new ADD is delivered with latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage issue front end: AluOp codes, RV32I opcodes,
// A-operand select and the decoded-instruction bundle.
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1010;
    localparam logic [3:0] ALU_SRA  = 4'b1011;
    localparam logic [3:0] ALU_OR   = 4'b1100;
    localparam logic [3:0] ALU_AND  = 4'b1110;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        A_RS1  = 2'b00,
        A_PC   = 2'b01,
        A_ZERO = 2'b10
    } a_sel_t;

    typedef struct packed {
        logic [3:0]  alu_op;
        a_sel_t      a_sel;
        logic        b_sel;
        logic [31:0] imm;
        logic        illegal;
    } dec_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decoder: instruction word to AluOp, operand selects,
// 32-bit sign-extended immediate and illegal flag.
module alu_decode
    import alu_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_shamt;
    logic        bad;
    dec_t        raw;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign imm_i     = {{20{instr[31]}}, instr[31:20]};
    assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u     = {instr[31:12], 12'h000};
    assign imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_shamt = {27'd0, instr[24:20]};

    always_comb begin
        raw       = '0;
        raw.a_sel = A_RS1;
        bad       = 1'b0;
        case (opcode)
            OPC_OP: begin
                raw.alu_op = {funct3, funct7[5]};
                if (funct7 == 7'b0100000)
                    bad = !((funct3 == 3'b000) || (funct3 == 3'b101));
                else if (funct7 != 7'b0000000)
                    bad = 1'b1;
            end
            OPC_OP_IMM: begin
                raw.b_sel = 1'b1;
                case (funct3)
                    3'b001: begin
                        raw.alu_op = ALU_SLL;
                        raw.imm    = imm_shamt;
                        bad        = (funct7 != 7'b0000000);
                    end
                    3'b101: begin
                        raw.alu_op = {funct3, funct7[5]};
                        raw.imm    = imm_shamt;
                        bad        = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
                    end
                    default: begin
                        raw.alu_op = {funct3, 1'b0};
                        raw.imm    = imm_i;
                    end
                endcase
            end
            OPC_LOAD: begin
                raw.alu_op = ALU_ADD;
                raw.b_sel  = 1'b1;
                raw.imm    = imm_i;
            end
            OPC_STORE: begin
                raw.alu_op = ALU_ADD;
                raw.b_sel  = 1'b1;
                raw.imm    = imm_s;
            end
            OPC_LUI: begin
                raw.alu_op = ALU_ADD;
                raw.a_sel  = A_ZERO;
                raw.b_sel  = 1'b1;
                raw.imm    = imm_u;
            end
            OPC_AUIPC: begin
                raw.alu_op = ALU_ADD;
                raw.a_sel  = A_PC;
                raw.b_sel  = 1'b1;
                raw.imm    = imm_u;
            end
            OPC_JAL: begin
                raw.alu_op = ALU_ADD;
                raw.a_sel  = A_PC;
                raw.b_sel  = 1'b1;
                raw.imm    = imm_j;
            end
            OPC_JALR: begin
                raw.alu_op = ALU_ADD;
                raw.b_sel  = 1'b1;
                raw.imm    = imm_i;
                bad        = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                raw.imm = imm_b;
                case (funct3)
                    3'b000, 3'b001: raw.alu_op = ALU_SUB;
                    3'b100, 3'b101: raw.alu_op = ALU_SLT;
                    3'b110, 3'b111: raw.alu_op = ALU_SLTU;
                    default:        bad = 1'b1;
                endcase
            end
            default: bad = 1'b1;
        endcase
        if (instr[1:0] != 2'b11)
            bad = 1'b1;

        // Illegal bundles travel with neutral controls so the ALU sees a harmless ADD.
        if (bad) begin
            dec         = '0;
            dec.a_sel   = A_RS1;
            dec.illegal = 1'b1;
        end else begin
            dec = raw;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Execute-stage issue front end: decodes an instruction and presents it through a
// registered output stage backed by a skid entry, keeping full throughput under backpressure.
module alu_issue
    import alu_pkg::*;
#(
    parameter int unsigned n = 32
) (
    input  logic         clock,
    input  logic         nReset,
    input  logic         InValid,
    output logic         InReady,
    input  logic [31:0]  Instr,
    input  logic [n-1:0] PcIn,
    output logic         OutValid,
    input  logic         OutReady,
    output logic [3:0]   AluOp,
    output logic [1:0]   ASel,
    output logic         BSel,
    output logic [n-1:0] Imm,
    output logic [n-1:0] PcOut,
    output logic         Illegal
);

    typedef struct packed {
        logic [3:0]   alu_op;
        logic [1:0]   a_sel;
        logic         b_sel;
        logic [n-1:0] imm;
        logic [n-1:0] pc;
        logic         illegal;
    } bundle_t;

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        TWO
    } state_t;

    dec_t    dec;
    bundle_t incoming;
    bundle_t main_q;
    bundle_t skid_q;
    state_t  state;
    logic    out_valid_q;
    logic    in_ready_q;
    logic    in_fire;
    logic    out_fire;

    alu_decode u_decode (
        .instr (Instr),
        .dec   (dec)
    );

    always_comb begin
        incoming         = '0;
        incoming.alu_op  = dec.alu_op;
        incoming.a_sel   = dec.a_sel;
        incoming.b_sel   = dec.b_sel;
        incoming.imm     = n'($signed(dec.imm));
        incoming.pc      = PcIn;
        incoming.illegal = dec.illegal;
    end

    assign in_fire  = InValid && in_ready_q;
    assign out_fire = out_valid_q && OutReady;

    // InReady is a flop tracking "skid empty", so OutReady never reaches it combinationally.
    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            state       <= EMPTY;
            main_q      <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        main_q      <= incoming;
                        out_valid_q <= 1'b1;
                        state       <= ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        main_q <= incoming;
                    end else if (in_fire) begin
                        skid_q     <= incoming;
                        in_ready_q <= 1'b0;
                        state      <= TWO;
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                        state       <= EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        main_q     <= skid_q;
                        in_ready_q <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign InReady  = in_ready_q;
    assign OutValid = out_valid_q;
    assign AluOp    = main_q.alu_op;
    assign ASel     = main_q.a_sel;
    assign BSel     = main_q.b_sel;
    assign Imm      = main_q.imm;
    assign PcOut    = main_q.pc;
    assign Illegal  = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed and random instructions scored against
// a behavioural decoder and an in-order queue of accepted bundles.
module tb_alu_issue;

    logic        clock = 1'b0;
    logic        nReset = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [31:0] Instr = '0;
    logic [31:0] PcIn = '0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [3:0]  AluOp;
    logic [1:0]  ASel;
    logic        BSel;
    logic [31:0] Imm;
    logic [31:0] PcOut;
    logic        Illegal;

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  asel;
        logic        bsel;
        logic [31:0] imm;
        logic        ill;
        logic [31:0] pc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;

    alu_issue #(.n(32)) dut (
        .clock    (clock),
        .nReset   (nReset),
        .InValid  (InValid),
        .InReady  (InReady),
        .Instr    (Instr),
        .PcIn     (PcIn),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .AluOp    (AluOp),
        .ASel     (ASel),
        .BSel     (BSel),
        .Imm      (Imm),
        .PcOut    (PcOut),
        .Illegal  (Illegal)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Decoder reference written from the instruction-set rules with integer arithmetic.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        int   opc, f3, f7, op, asel, bsel, imm;
        bit   ok;
        opc = int'(ins[6:0]);
        f3  = int'(ins[14:12]);
        f7  = int'(ins[31:25]);
        ok = 1; op = 0; asel = 0; bsel = 0; imm = 0;
        case (opc)
            'h33: begin
                ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                op = f3 * 2 + ((f7 == 32) ? 1 : 0);
            end
            'h13: begin
                bsel = 1;
                if (f3 == 1) begin
                    ok = (f7 == 0); imm = int'(ins[24:20]); op = 2;
                end else if (f3 == 5) begin
                    ok = (f7 == 0) || (f7 == 32); imm = int'(ins[24:20]);
                    op = 10 + ((f7 == 32) ? 1 : 0);
                end else begin
                    imm = int'($signed(ins[31:20])); op = f3 * 2;
                end
            end
            'h03: begin bsel = 1; imm = int'($signed(ins[31:20])); end
            'h23: begin bsel = 1; imm = int'($signed({ins[31:25], ins[11:7]})); end
            'h37: begin asel = 2; bsel = 1; imm = int'({ins[31:12], 12'h000}); end
            'h17: begin asel = 1; bsel = 1; imm = int'({ins[31:12], 12'h000}); end
            'h6F: begin
                asel = 1; bsel = 1;
                imm = int'($signed({ins[31], ins[19:12], ins[20], ins[30:21]})) * 2;
            end
            'h67: begin ok = (f3 == 0); bsel = 1; imm = int'($signed(ins[31:20])); end
            'h63: begin
                imm = int'($signed({ins[31], ins[7], ins[30:25], ins[11:8]})) * 2;
                if (f3 == 0 || f3 == 1)      op = 1;
                else if (f3 == 4 || f3 == 5) op = 4;
                else if (f3 == 6 || f3 == 7) op = 6;
                else                         ok = 0;
            end
            default: ok = 0;
        endcase
        if (ins[1:0] != 2'b11) ok = 0;
        if (!ok) begin op = 0; asel = 0; bsel = 0; imm = 0; end
        e.op   = 4'(op);
        e.asel = 2'(asel);
        e.bsel = bsel[0];
        e.imm  = 32'(imm);
        e.ill  = !ok;
        e.pc   = pc;
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [6:0]  opcs [10];
        logic [6:0]  f7s [3];
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h00};
        f7s  = '{7'h00, 7'h20, 7'h00};
        ins = $urandom;
        f7s[2] = ins[31:25];
        ins[6:0] = opcs[$urandom_range(0, 9)];
        if (ins[6:0] == 7'h00) ins[6:0] = 7'($urandom);
        if (ins[6:0] == 7'h33 || ins[6:0] == 7'h13) ins[31:25] = f7s[$urandom_range(0, 2)];
        return ins;
    endfunction

    task automatic check_outputs();
        chk("out_valid", 32'(OutValid), 32'(q.size() != 0));
        chk("in_ready", 32'(InReady), 32'(q.size() < 2));
        if (q.size() != 0) begin
            chk("alu_op", 32'(AluOp), 32'(q[0].op));
            chk("a_sel", 32'(ASel), 32'(q[0].asel));
            chk("b_sel", 32'(BSel), 32'(q[0].bsel));
            chk("imm", Imm, q[0].imm);
            chk("pc_out", PcOut, q[0].pc);
            chk("illegal", 32'(Illegal), 32'(q[0].ill));
        end
    endtask

    // One clock: check at the falling edge, drive, then apply both handshakes to the model.
    task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy);
        logic in_f, out_f;
        check_outputs();
        InValid  = v;
        Instr    = ins;
        PcIn     = pc;
        OutReady = rdy;
        #1;
        in_f  = InValid && InReady;
        out_f = OutValid && OutReady;
        @(posedge clock);
        if (out_f) void'(q.pop_front());
        if (in_f) q.push_back(ref_decode(ins, pc));
        @(negedge clock);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_out_valid"}, 32'(OutValid), 32'd0);
        chk({tag, "_in_ready"}, 32'(InReady), 32'd1);
        chk({tag, "_alu_op"}, 32'(AluOp), 32'd0);
        chk({tag, "_a_sel"}, 32'(ASel), 32'd0);
        chk({tag, "_b_sel"}, 32'(BSel), 32'd0);
        chk({tag, "_imm"}, Imm, 32'd0);
        chk({tag, "_pc_out"}, PcOut, 32'd0);
        chk({tag, "_illegal"}, 32'(Illegal), 32'd0);
    endtask

    initial begin
        logic [31:0] pc;

        @(negedge clock);
        check_reset_values("reset");
        nReset = 1'b1;
        @(negedge clock);

        // ADD with latency 1
        cycle(1'b1, 32'h002081B3, 32'h100, 1'b1);
        chk("add_valid", 32'(OutValid), 32'd1);
        chk("add_op", 32'(AluOp), 32'h0);
        chk("add_pc", PcOut, 32'h100);
        chk("add_ill", 32'(Illegal), 32'd0);

        // SUB then SRAI back-to-back
        cycle(1'b1, 32'h402081B3, 32'h104, 1'b1);
        chk("sub_op", 32'(AluOp), 32'h1);
        cycle(1'b1, 32'h40315093, 32'h108, 1'b1);
        chk("srai_op", 32'(AluOp), 32'hB);
        chk("srai_bsel", 32'(BSel), 32'd1);
        chk("srai_imm", Imm, 32'h3);

        // LUI and BLTU with a negative offset
        cycle(1'b1, 32'h123452B7, 32'h10C, 1'b1);
        chk("lui_asel", 32'(ASel), 32'h2);
        chk("lui_imm", Imm, 32'h12345000);
        cycle(1'b1, 32'hFE20ECE3, 32'h110, 1'b1);
        chk("bltu_op", 32'(AluOp), 32'h6);
        chk("bltu_imm", Imm, 32'hFFFFFFF8);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);

        // Backpressure: A to main, B to skid, C held off
        cycle(1'b1, 32'h002081B3, 32'h300, 1'b0);
        cycle(1'b1, 32'h402081B3, 32'h304, 1'b0);
        chk("bp_c_held", 32'(InReady), 32'd0);
        cycle(1'b1, 32'h00A00093, 32'h308, 1'b0);
        chk("bp_hold_a", PcOut, 32'h300);
        cycle(1'b1, 32'h00A00093, 32'h308, 1'b1);
        chk("bp_then_b", PcOut, 32'h304);
        cycle(1'b1, 32'h00A00093, 32'h308, 1'b1);
        chk("bp_then_c", PcOut, 32'h308);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
        chk("bp_drained", 32'(OutValid), 32'd0);

        // Illegal encodings still delivered
        cycle(1'b1, 32'h0000007F, 32'h500, 1'b1);
        chk("ill_opc", 32'(Illegal), 32'd1);
        chk("ill_opc_op", 32'(AluOp), 32'd0);
        cycle(1'b1, 32'h022081B3, 32'h504, 1'b1);
        chk("ill_f7", 32'(Illegal), 32'd1);
        chk("ill_f7_valid", 32'(OutValid), 32'd1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);

        // Random traffic with random backpressure
        pc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            pc = pc + 32'd4;
            cycle($urandom_range(0, 3) != 0, rand_instr(), pc, $urandom_range(0, 2) != 0);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1);
        chk("drain_empty", 32'(q.size()), 32'd0);

        // Reset with both entries full
        cycle(1'b1, 32'h002081B3, 32'h400, 1'b0);
        cycle(1'b1, 32'h402081B3, 32'h404, 1'b0);
        chk("pre_reset_full", 32'(InReady), 32'd0);
        InValid = 1'b0;
        #1 nReset = 1'b0;
        #1 check_reset_values("midreset");
        q.delete();
        @(negedge clock);
        nReset = 1'b1;
        @(negedge clock);
        cycle(1'b1, 32'h002081B3, 32'h200, 1'b1);
        chk("post_reset_valid", 32'(OutValid), 32'd1);
        chk("post_reset_pc", PcOut, 32'h200);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
